// File: rtl/baccarat_pkg.sv
// Shared state encoding, result codes and card arithmetic for the baccarat round engine.
package baccarat_pkg;

  typedef enum logic [2:0] {IDLE, DEAL1, DEAL2, CHECK, P3, B3DEC, B3, RESULT} state_t;

  localparam logic [1:0] RES_NONE   = 2'b00;
  localparam logic [1:0] RES_PLAYER = 2'b01;
  localparam logic [1:0] RES_BANKER = 2'b10;
  localparam logic [1:0] RES_TIE    = 2'b11;

  function automatic logic [3:0] card_value(input logic [3:0] rank);
    return (rank >= 4'd10) ? 4'd0 : rank;
  endfunction

  function automatic logic [3:0] score3(input logic [3:0] c1, input logic [3:0] c2,
                                        input logic [3:0] c3);
    logic [4:0] s;
    s = {1'b0, card_value(c1)} + {1'b0, card_value(c2)} + {1'b0, card_value(c3)};
    return (s >= 5'd20) ? 4'(s - 5'd20) : (s >= 5'd10) ? 4'(s - 5'd10) : 4'(s);
  endfunction

  // Tableau keyed on the banker score and the value of hand 0's third card.
  function automatic logic banker_draws(input logic [3:0] bscore, input logic p_drew,
                                        input logic [3:0] p3val);
    logic d;
    if (!p_drew) d = (bscore <= 4'd5);
    else begin
      case (bscore)
        4'd0, 4'd1, 4'd2: d = 1'b1;
        4'd3:    d = (p3val != 4'd8);
        4'd4:    d = (p3val >= 4'd2) && (p3val <= 4'd7);
        4'd5:    d = (p3val >= 4'd4) && (p3val <= 4'd7);
        4'd6:    d = (p3val >= 4'd6) && (p3val <= 4'd7);
        default: d = 1'b0;
      endcase
    end
    return d;
  endfunction

endpackage

// File: rtl/baccarat_hand_reg.sv
// hand_reg: three 4-bit card slots of one hand with slot-indexed load, clear and live score.
module hand_reg
  import baccarat_pkg::*;
(
  input  logic        slow_clock,
  input  logic        resetb,
  input  logic        clear,
  input  logic        load,
  input  logic [1:0]  slot,
  input  logic [3:0]  card,
  output logic [11:0] cards,
  output logic [3:0]  score
);

  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) cards <= '0;
    else if (clear) cards <= '0;
    else if (load) begin
      case (slot)
        2'd0:    cards[3:0]  <= card;
        2'd1:    cards[7:4]  <= card;
        default: cards[11:8] <= card;
      endcase
    end
  end

  assign score = score3(cards[3:0], cards[7:4], cards[11:8]);

endmodule

// File: rtl/baccarat_table.sv
// Baccarat round engine: deals N_HANDS player hands plus a banker hand from a valid/ready card stream.
// Define TABLE_TALLY_EN to add saturating per-hand win counters (hand_wins/banker_wins).
module baccarat_table
  import baccarat_pkg::*;
#(
  parameter int N_HANDS = 1,
  parameter int TALLY_W = 8
) (
  input  logic                  slow_clock,
  input  logic                  resetb,
  input  logic                  start,
  input  logic                  card_valid,
  input  logic [3:0]            card,
  output logic                  card_ready,
  output logic [N_HANDS*12-1:0] hand_cards,
  output logic [11:0]           banker_cards,
  output logic [N_HANDS*4-1:0]  hand_score,
  output logic [3:0]            banker_score,
  output logic [N_HANDS*2-1:0]  hand_result,
  output logic                  busy,
  output logic                  done
`ifdef TABLE_TALLY_EN
  ,
  output logic [N_HANDS*TALLY_W-1:0] hand_wins,
  output logic [N_HANDS*TALLY_W-1:0] banker_wins
`endif
);

  // pos walks the hands in deal order; BANK addresses the banker register
  localparam logic [2:0] BANK = 3'(N_HANDS);

  state_t                  state, state_n;
  logic [2:0]              pos, pos_n;
  logic [N_HANDS-1:0]      draw, draw_n;
  logic [N_HANDS*2-1:0]    result_n;
  logic                    busy_n, done_n, clear, take, natural;
  logic [1:0]              slot;
  logic [N_HANDS:0]        load;
  logic [N_HANDS:0][11:0]  cards_all;
  logic [N_HANDS:0][3:0]   score_all;

  assign card_ready = (state == DEAL1) || (state == DEAL2) || (state == P3) || (state == B3);
  // Out-of-range ranks complete the handshake but never reach a register
  assign take = card_valid && card_ready && (card >= 4'd1) && (card <= 4'd13);
  assign slot = (state == DEAL1) ? 2'd0 : (state == DEAL2) ? 2'd1 : 2'd2;

  for (genvar g = 0; g <= N_HANDS; g++) begin : g_hand
    assign load[g] = take && (pos == 3'(g));
    hand_reg u_hand (
      .slow_clock(slow_clock),
      .resetb    (resetb),
      .clear     (clear),
      .load      (load[g]),
      .slot      (slot),
      .card      (card),
      .cards     (cards_all[g]),
      .score     (score_all[g])
    );
  end

  for (genvar g = 0; g < N_HANDS; g++) begin : g_out
    assign hand_cards[g*12 +: 12] = cards_all[g];
    assign hand_score[g*4 +: 4]   = score_all[g];
  end
  assign banker_cards = cards_all[N_HANDS];
  assign banker_score = score_all[N_HANDS];

  always_comb begin
    state_n  = state;
    pos_n    = pos;
    draw_n   = draw;
    busy_n   = busy;
    done_n   = 1'b0;
    result_n = hand_result;
    clear    = 1'b0;
    natural  = 1'b0;
    case (state)
      IDLE: if (start) begin
        clear    = 1'b1;
        result_n = {N_HANDS{RES_NONE}};
        busy_n   = 1'b1;
        pos_n    = '0;
        draw_n   = '0;
        state_n  = DEAL1;
      end
      DEAL1, DEAL2: if (take) begin
        if (pos == BANK) begin
          pos_n   = '0;
          state_n = (state == DEAL1) ? DEAL2 : CHECK;
        end else pos_n = pos + 3'd1;
      end
      CHECK: begin
        for (int i = 0; i <= N_HANDS; i++) natural = natural | (score_all[i] >= 4'd8);
        if (natural) state_n = RESULT;
        else begin
          for (int i = N_HANDS - 1; i >= 0; i--) begin
            draw_n[i] = (score_all[i] <= 4'd5);
            if (draw_n[i]) pos_n = 3'(i);
          end
          state_n = (|draw_n) ? P3 : B3DEC;
        end
      end
      P3: if (take) begin
        state_n = B3DEC;
        for (int i = N_HANDS - 1; i >= 0; i--) begin
          if (draw[i] && (3'(i) > pos)) begin
            pos_n   = 3'(i);
            state_n = P3;
          end
        end
      end
      B3DEC: begin
        if (banker_draws(score_all[N_HANDS], draw[0], card_value(cards_all[0][11:8]))) begin
          pos_n   = BANK;
          state_n = B3;
        end else state_n = RESULT;
      end
      B3: if (take) state_n = RESULT;
      RESULT: begin
        for (int i = 0; i < N_HANDS; i++) begin
          if (score_all[i] > score_all[N_HANDS])      result_n[2*i +: 2] = RES_PLAYER;
          else if (score_all[i] < score_all[N_HANDS]) result_n[2*i +: 2] = RES_BANKER;
          else                                        result_n[2*i +: 2] = RES_TIE;
        end
        done_n  = 1'b1;
        busy_n  = 1'b0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      state       <= IDLE;
      pos         <= '0;
      draw        <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      hand_result <= {N_HANDS{RES_NONE}};
    end else begin
      state       <= state_n;
      pos         <= pos_n;
      draw        <= draw_n;
      busy        <= busy_n;
      done        <= done_n;
      hand_result <= result_n;
    end
  end

`ifdef TABLE_TALLY_EN
  logic [N_HANDS-1:0][TALLY_W-1:0] wins_p, wins_b;

  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      wins_p <= '0;
      wins_b <= '0;
    end else if (state == RESULT) begin
      for (int i = 0; i < N_HANDS; i++) begin
        if ((result_n[2*i +: 2] == RES_PLAYER) && (wins_p[i] != '1)) wins_p[i] <= wins_p[i] + 1'b1;
        if ((result_n[2*i +: 2] == RES_BANKER) && (wins_b[i] != '1)) wins_b[i] <= wins_b[i] + 1'b1;
      end
    end
  end

  assign hand_wins   = wins_p;
  assign banker_wins = wins_b;
`endif

endmodule

// File: tb/tb_baccarat_table.sv
// Scoreboard bench for baccarat_table: random decks, junk ranks, stalls and a mid-round reset.
module tb_baccarat_table;
  localparam int NH = 2;
  localparam int TW = 2;

  logic slow_clock = 1'b0, resetb = 1'b0, start = 1'b0, card_valid = 1'b0;
  logic [3:0] card = 4'd0;
  logic card_ready, busy, done;
  logic [NH*12-1:0] hand_cards;
  logic [11:0] banker_cards;
  logic [NH*4-1:0] hand_score;
  logic [3:0] banker_score;
  logic [NH*2-1:0] hand_result;
`ifdef TABLE_TALLY_EN
  logic [NH*TW-1:0] hand_wins, banker_wins;
`endif

  int checks = 0, errors = 0;

  typedef struct {
    logic [NH*12-1:0] hc;
    logic [11:0]      bc;
    logic [NH*4-1:0]  hs;
    logic [3:0]       bs;
    logic [NH*2-1:0]  hr;
    logic [NH*TW-1:0] hw, bw;
    int               ncards;
  } exp_t;

  exp_t exp_q[$];
  int tally_p[NH], tally_b[NH];

  always #5 slow_clock = ~slow_clock;

  baccarat_table #(.N_HANDS(NH), .TALLY_W(TW)) dut (
`ifdef TABLE_TALLY_EN
    .hand_wins(hand_wins), .banker_wins(banker_wins),
`endif
    .slow_clock(slow_clock), .resetb(resetb), .start(start), .card_valid(card_valid),
    .card(card), .card_ready(card_ready), .hand_cards(hand_cards), .banker_cards(banker_cards),
    .hand_score(hand_score), .banker_score(banker_score), .hand_result(hand_result),
    .busy(busy), .done(done)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int val(input int r);
    return (r >= 10) ? 0 : r;
  endfunction

  // Plays one round straight from the rules of the game, consuming the deck in deal order.
  task automatic model(input int deck[9], output exp_t e);
    int p[NH][3];
    int b[3];
    int ps[NH];
    bit drew[NH];
    int k, bsc, p3;
    bit nat, bd;
    k = 0;
    for (int h = 0; h < NH; h++) begin p[h][0] = 0; p[h][1] = 0; p[h][2] = 0; drew[h] = 0; end
    b[0] = 0; b[1] = 0; b[2] = 0;
    for (int r = 0; r < 2; r++) begin
      for (int h = 0; h < NH; h++) p[h][r] = deck[k++];
      b[r] = deck[k++];
    end
    for (int h = 0; h < NH; h++) ps[h] = (val(p[h][0]) + val(p[h][1])) % 10;
    bsc = (val(b[0]) + val(b[1])) % 10;
    nat = (bsc >= 8);
    for (int h = 0; h < NH; h++) if (ps[h] >= 8) nat = 1;
    if (!nat) begin
      for (int h = 0; h < NH; h++) begin
        if (ps[h] <= 5) begin
          drew[h] = 1;
          p[h][2] = deck[k++];
          ps[h] = (ps[h] + val(p[h][2])) % 10;
        end
      end
      p3 = val(p[0][2]);
      if (!drew[0]) bd = (bsc <= 5);
      else bd = (bsc <= 2) || (bsc == 3 && p3 != 8) || (bsc == 4 && p3 >= 2 && p3 <= 7) ||
                (bsc == 5 && p3 >= 4 && p3 <= 7) || (bsc == 6 && p3 >= 6 && p3 <= 7);
      if (bd) begin
        b[2] = deck[k++];
        bsc = (bsc + val(b[2])) % 10;
      end
    end
    e.hc = '0; e.hs = '0; e.hr = '0; e.hw = '0; e.bw = '0;
    for (int h = 0; h < NH; h++) begin
      e.hc[h*12 +: 12] = {4'(p[h][2]), 4'(p[h][1]), 4'(p[h][0])};
      e.hs[h*4 +: 4] = 4'(ps[h]);
      if (ps[h] > bsc) begin
        e.hr[h*2 +: 2] = 2'b01;
        if (tally_p[h] < (1 << TW) - 1) tally_p[h]++;
      end else if (ps[h] < bsc) begin
        e.hr[h*2 +: 2] = 2'b10;
        if (tally_b[h] < (1 << TW) - 1) tally_b[h]++;
      end else e.hr[h*2 +: 2] = 2'b11;
      e.hw[h*TW +: TW] = TW'(tally_p[h]);
      e.bw[h*TW +: TW] = TW'(tally_b[h]);
    end
    e.bc = {4'(b[2]), 4'(b[1]), 4'(b[0])};
    e.bs = 4'(bsc);
    e.ncards = k;
  endtask

  task automatic run_round(input int deck[9]);
    exp_t e;
    int idx, guard, j;
    bit junk, rdy;
    model(deck, e);
    exp_q.push_back(e);
    @(negedge slow_clock) start = 1'b1;
    @(negedge slow_clock) start = 1'b0;
    idx = 0;
    guard = 0;
    while (idx < e.ncards && guard < 3000) begin
      guard++;
      if ($urandom_range(0, 19) == 0) begin
        card_valid = 1'b0;
        repeat (20) @(negedge slow_clock);
        chk("stall_ready", card_ready, 1);
        chk("stall_busy", busy, 1);
      end
      card_valid = ($urandom_range(0, 3) != 0);
      junk = ($urandom_range(0, 7) == 0);
      j = $urandom_range(0, 2);
      card = junk ? ((j == 0) ? 4'd0 : (j == 1) ? 4'd14 : 4'd15) : 4'(deck[idx]);
      start = ($urandom_range(0, 5) == 0);
      rdy = card_ready;
      @(posedge slow_clock);
      if (card_valid && rdy && !junk) idx++;
      @(negedge slow_clock);
    end
    card_valid = 1'b0;
    start = 1'b0;
    chk("cards_consumed", idx, e.ncards);
    chk("ready_after_last", card_ready, 0);
    guard = 0;
    while (!done && guard < 8) begin
      @(negedge slow_clock);
      guard++;
    end
    chk("done_within_bound", (guard < 8), 1);
    @(negedge slow_clock);
  endtask

  task automatic abort_round();
    int cnt, guard;
    bit rdy;
    @(negedge slow_clock) start = 1'b1;
    @(negedge slow_clock) start = 1'b0;
    card = 4'd1;
    card_valid = 1'b1;
    cnt = 0;
    guard = 0;
    // Seven aces: all hands score 2 and draw; hand 1's third card is still pending
    while (cnt < 7 && guard < 100) begin
      guard++;
      rdy = card_ready;
      @(posedge slow_clock);
      if (rdy) cnt++;
      @(negedge slow_clock);
    end
    card_valid = 1'b0;
    chk("abort_in_p3_ready", card_ready, 1);
    resetb = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", card_ready, 0);
    chk("rst_hand_cards", hand_cards, 0);
    chk("rst_banker_cards", banker_cards, 0);
    chk("rst_hand_score", hand_score, 0);
    chk("rst_banker_score", banker_score, 0);
    chk("rst_hand_result", hand_result, 0);
`ifdef TABLE_TALLY_EN
    chk("rst_hand_wins", hand_wins, 0);
    chk("rst_banker_wins", banker_wins, 0);
`endif
    for (int h = 0; h < NH; h++) begin tally_p[h] = 0; tally_b[h] = 0; end
    @(negedge slow_clock) resetb = 1'b1;
    @(negedge slow_clock);
  endtask

  always @(negedge slow_clock) begin
    exp_t e;
    if (resetb && done) begin
      chk("done_has_round", (exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("hand_cards", hand_cards, e.hc);
        chk("banker_cards", banker_cards, e.bc);
        chk("hand_score", hand_score, e.hs);
        chk("banker_score", banker_score, e.bs);
        chk("hand_result", hand_result, e.hr);
        chk("busy_at_done", busy, 0);
`ifdef TABLE_TALLY_EN
        #2;
        chk("hand_wins", hand_wins, e.hw);
        chk("banker_wins", banker_wins, e.bw);
`endif
      end
    end
  end

  initial begin
    int deck[9];
    for (int h = 0; h < NH; h++) begin tally_p[h] = 0; tally_b[h] = 0; end
    repeat (3) @(negedge slow_clock);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_ready", card_ready, 0);
    chk("reset_hand_cards", hand_cards, 0);
    chk("reset_banker_cards", banker_cards, 0);
    chk("reset_hand_result", hand_result, 0);
    resetb = 1'b1;
    @(negedge slow_clock);
    deck = '{1, 2, 3, 1, 2, 3, 7, 5, 4};
    run_round(deck);
    deck = '{4, 1, 2, 4, 1, 3, 9, 9, 9};
    run_round(deck);
    deck = '{5, 13, 3, 11, 12, 7, 4, 6, 9};
    run_round(deck);
    deck = '{2, 6, 3, 3, 1, 3, 8, 9, 9};
    run_round(deck);
    for (int r = 0; r < 25; r++) begin
      for (int k = 0; k < 9; k++) deck[k] = $urandom_range(1, 13);
      run_round(deck);
    end
    abort_round();
    for (int r = 0; r < 20; r++) begin
      for (int k = 0; k < 9; k++) deck[k] = $urandom_range(1, 13);
      run_round(deck);
    end
    repeat (5) @(negedge slow_clock);
    chk("pending_results", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout: simulation did not complete, errors so far %0d", errors);
    $fatal(1);
  end

endmodule
